edf_dispatcher: RTL and testbench
=================================

// Module: edf_dispatcher
// PURPOSE
// - Downstream stage of the per-core request queues: arbitrates NB_QUEUES queue heads by earliest deadline (EDF).
// - Reads the winning queue's BRAM-backed head and pulses that queue's consumed strobe.
// - Presents the entry to the memory-side port through a valid/ready handshake.
// - Tracks a per-queue countdown deadline; flags misses for software.
// PARAMETERS
// - NB_QUEUES      4   number of upstream queues (>=2)
// - DATA_SIZE      8   width of one queue entry
// - REGISTER_SIZE  32  width of period/deadline registers
// PORTS
// - clock              in   1                        single clock; all logic on posedge
// - reset              in   1                        asynchronous, active-high; all state cleared immediately
// - q_valueOut         in   NB_QUEUES*DATA_SIZE      flattened queue head values (queue i at [i*DATA_SIZE +: DATA_SIZE])
// - q_empty            in   NB_QUEUES                queue empty flags
// - q_consumed         out  NB_QUEUES                one-cycle pop strobe per queue (at most one bit high)
// - period             in   NB_QUEUES*REGISTER_SIZE  relative deadline per queue in cycles; 0 = best-effort
// - miss_clear         in   NB_QUEUES                clears the matching sticky miss flag
// - deadline_miss      out  NB_QUEUES                sticky miss flags
// - m_data             out  DATA_SIZE                dispatched entry
// - m_source           out  $clog2(NB_QUEUES)        index of the queue that produced m_data
// - m_valid            out  1                        m_data/m_source valid
// - m_ready            in   1                        downstream accepts when m_valid & m_ready
// BEHAVIOUR
// - Reset values: m_valid=0, m_data=0, m_source=0, q_consumed=0, deadline_miss=0, state=IDLE, remaining[*]=0, settle[*]=0.
// - Eligibility:
//   - queue i is eligible iff !q_empty[i] and settle[i]==0.
//   - settle[i] is set to 2 in the cycle q_consumed[i] pulses and decrements to 0.
//   - This covers the 1-cycle head-pointer update plus the 1-cycle registered BRAM read, so a stale head is never re-read.
// - Selection (combinational, edf_min_select):
//   - Among eligible queues with period!=0, pick the minimum remaining[i]; ties go to the lowest index.
//   - If none exist, pick the lowest-index eligible best-effort queue (period==0).
// - FSM:
//   - IDLE: if any queue is eligible, load m_data<=q_valueOut[sel], m_source<=sel, m_valid<=1, pulse q_consumed[sel] that same cycle, go to ISSUE.
//   - ISSUE: hold m_data/m_source stable while !m_ready.
//   - On m_valid&m_ready, if an eligible queue exists: reload and pulse as in IDLE, stay in ISSUE (back-to-back, 1 entry/cycle peak).
//   - Otherwise: m_valid<=0, go to IDLE.
// - Deadlines, per queue, every cycle:
//   - if q_empty[i]: remaining<=period[i];
//   - else if q_consumed[i]: remaining<=period[i] (next head gets a fresh deadline);
//   - else if remaining!=0: remaining<=remaining-1;
//   - else if period[i]!=0: deadline_miss[i]<=1, and remaining saturates at 0.
// - miss_clear[i] wins over a same-cycle set; a miss in the following cycle sets the flag again.
// - A period change takes effect at the next reload only; an in-flight countdown is not rescaled.
// - Unsigned arithmetic, no wrap: the decrement is guarded by !=0.
// - A queue that becomes empty while still settling is simply ineligible; no pop is issued to an empty queue.
// - Asserting reset mid-transfer drops m_valid asynchronously; the in-flight entry is lost, and the queues are reset by the same signal.
// CONFIGURATION
// - Optional feature macro: MEMOREDF_MISS_CNT_EN.
// - Defined:
//   - adds output miss_count (NB_QUEUES*16 bits): per-queue saturating 16-bit counters of miss events (rising edge of the miss condition), reset to 0.
//   - Each counter is cleared by its miss_clear bit.
// - Undefined: the port and counters are absent; the deadline_miss behaviour is identical.
// STRUCTURE
// - memoredf_pkg: typedef enum logic {IDLE, ISSUE} disp_state_t; localparam SETTLE_CYCLES=2; function qidx_w(n)=$clog2(n).
// - Sub-module edf_min_select: combinational argmin tree over remaining/eligible/best_effort; outputs sel index and any_eligible.
// TESTING
// - Reset: reset=1 mid-ISSUE with m_ready=0 -> m_valid=0, q_consumed=0 in the same cycle; after release the state is IDLE.
// - Single queue: q_empty=4'b1110, value 8'hA5 -> next edge m_valid=1, m_data=A5, m_source=0, q_consumed=0001 for one cycle; queue 0 is not reselected for 2 cycles.
// - EDF order: periods {100,20,50,0}, all queues non-empty from the same cycle -> dispatch order 1,2,0,3.
// - Tie: periods {30,30,-,-}, queues 0 and 1 filled together -> queue 0 wins.
// - Backpressure: m_ready=0 for 10 cycles -> m_data/m_source stable, no further q_consumed.
// - Back-to-back: m_ready=1 with two eligible queues -> consecutive-cycle dispatches.
// - Miss: period[2]=5, queue 2 non-empty, m_ready=0 -> deadline_miss[2]=1 after 6 cycles; miss_clear[2] pulse -> 0 for one cycle, then 1 again while still starved.

Source files
------------

// File: rtl/memoredf_pkg.sv
// rtl/memoredf_pkg.sv - shared types, constants and helpers for the EDF dispatcher
package memoredf_pkg;

  typedef enum logic {IDLE, ISSUE} disp_state_t;

  // Cycles a popped queue stays ineligible: head-pointer update plus registered BRAM read
  localparam int SETTLE_CYCLES = 2;

  function automatic int qidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edf_dispatcher_if.sv
// rtl/edf_dispatcher_if.sv - memory-side valid/ready port of the EDF dispatcher
interface edf_dispatcher_if #(
  parameter int NB_QUEUES = 4,
  parameter int DATA_SIZE = 8
) ();

  localparam int QW = memoredf_pkg::qidx_w(NB_QUEUES);

  logic [DATA_SIZE-1:0] m_data;
  logic [QW-1:0]        m_source;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_source, output m_valid, input m_ready);
  modport slave  (input m_data, input m_source, input m_valid, output m_ready);

endinterface

// File: rtl/edf_min_select.sv
// rtl/edf_min_select.sv - earliest-deadline argmin over eligible queues with best-effort fallback
module edf_min_select
  import memoredf_pkg::*;
#(
  parameter int NB_QUEUES     = 4,
  parameter int REGISTER_SIZE = 32
) (
  input  logic [NB_QUEUES*REGISTER_SIZE-1:0]  remaining,
  input  logic [NB_QUEUES-1:0]                eligible,
  input  logic [NB_QUEUES-1:0]                best_effort,
  output logic [qidx_w(NB_QUEUES)-1:0]        sel,
  output logic                                any_eligible
);

  localparam int QW = qidx_w(NB_QUEUES);

  logic                     found_rt;
  logic                     found_be;
  logic [REGISTER_SIZE-1:0] best_rem;
  logic [QW-1:0]            sel_rt;
  logic [QW-1:0]            sel_be;

  // Strict less-than keeps the lowest index on ties; deadline queues always beat best-effort ones
  always_comb begin
    found_rt = 1'b0;
    found_be = 1'b0;
    best_rem = '0;
    sel_rt   = '0;
    sel_be   = '0;
    for (int i = 0; i < NB_QUEUES; i++) begin
      if (eligible[i] && !best_effort[i] &&
          (!found_rt || remaining[i*REGISTER_SIZE +: REGISTER_SIZE] < best_rem)) begin
        found_rt = 1'b1;
        best_rem = remaining[i*REGISTER_SIZE +: REGISTER_SIZE];
        sel_rt   = QW'(i);
      end
      if (eligible[i] && best_effort[i] && !found_be) begin
        found_be = 1'b1;
        sel_be   = QW'(i);
      end
    end
    sel          = found_rt ? sel_rt : sel_be;
    any_eligible = |eligible;
  end

endmodule

// File: rtl/edf_dispatcher.sv
// rtl/edf_dispatcher.sv - EDF arbiter over queue heads with deadline tracking (option: MEMOREDF_MISS_CNT_EN)
module edf_dispatcher
  import memoredf_pkg::*;
#(
  parameter int NB_QUEUES     = 4,
  parameter int DATA_SIZE     = 8,
  parameter int REGISTER_SIZE = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NB_QUEUES*DATA_SIZE-1:0]     q_valueOut,
  input  logic [NB_QUEUES-1:0]               q_empty,
  output logic [NB_QUEUES-1:0]               q_consumed,
  input  logic [NB_QUEUES*REGISTER_SIZE-1:0] period,
  input  logic [NB_QUEUES-1:0]               miss_clear,
  output logic [NB_QUEUES-1:0]               deadline_miss,
`ifdef MEMOREDF_MISS_CNT_EN
  output logic [NB_QUEUES*16-1:0]            miss_count,
`endif
  edf_dispatcher_if.master                   mem
);

  localparam int                       QW          = qidx_w(NB_QUEUES);
  localparam logic [1:0]               SETTLE_INIT = 2'(SETTLE_CYCLES);
  localparam logic [REGISTER_SIZE-1:0] ONE_R       = 1;

  disp_state_t                                state, state_nx;
  logic [NB_QUEUES-1:0][REGISTER_SIZE-1:0]    remaining;
  logic [NB_QUEUES-1:0][1:0]                  settle;
  logic [NB_QUEUES-1:0]                       eligible;
  logic [NB_QUEUES-1:0]                       best_effort;
  logic [NB_QUEUES-1:0]                       miss_evt;
  logic [QW-1:0]                              sel;
  logic                                       any_eligible;
  logic                                       load;

  // Per-queue eligibility, best-effort class and the raw miss condition
  always_comb begin
    eligible    = '0;
    best_effort = '0;
    miss_evt    = '0;
    for (int i = 0; i < NB_QUEUES; i++) begin
      best_effort[i] = (period[i*REGISTER_SIZE +: REGISTER_SIZE] == '0);
      eligible[i]    = !q_empty[i] && (settle[i] == 2'd0);
      miss_evt[i]    = !q_empty[i] && !q_consumed[i] && (remaining[i] == '0) && !best_effort[i];
    end
  end

  edf_min_select #(
    .NB_QUEUES     (NB_QUEUES),
    .REGISTER_SIZE (REGISTER_SIZE)
  ) u_min_select (
    .remaining    (remaining),
    .eligible     (eligible),
    .best_effort  (best_effort),
    .sel          (sel),
    .any_eligible (any_eligible)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and load decision: a new head is taken whenever the output slot is free or draining
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          load     = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (mem.m_ready) begin
          if (any_eligible) load = 1'b1;
          else              state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output register and one-cycle pop strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem.m_data   <= '0;
      mem.m_source <= '0;
      mem.m_valid  <= 1'b0;
      q_consumed   <= '0;
    end else begin
      q_consumed  <= '0;
      mem.m_valid <= (state_nx == ISSUE);
      if (load) begin
        mem.m_data      <= q_valueOut[sel*DATA_SIZE +: DATA_SIZE];
        mem.m_source    <= sel;
        q_consumed[sel] <= 1'b1;
      end
    end
  end

  // Settle counters keep a just-popped queue out of arbitration until its new head is readable
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle <= '0;
    end else begin
      for (int i = 0; i < NB_QUEUES; i++) begin
        if (load && (sel == QW'(i))) settle[i] <= SETTLE_INIT;
        else if (settle[i] != 2'd0)  settle[i] <= settle[i] - 2'd1;
      end
    end
  end

  // Deadline countdown per queue head and sticky miss flags; clear beats a same-cycle set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining     <= '0;
      deadline_miss <= '0;
    end else begin
      for (int i = 0; i < NB_QUEUES; i++) begin
        if (q_empty[i] || q_consumed[i])
          remaining[i] <= period[i*REGISTER_SIZE +: REGISTER_SIZE];
        else if (remaining[i] != '0)
          remaining[i] <= remaining[i] - ONE_R;
        if (miss_clear[i])    deadline_miss[i] <= 1'b0;
        else if (miss_evt[i]) deadline_miss[i] <= 1'b1;
      end
    end
  end

`ifdef MEMOREDF_MISS_CNT_EN
  logic [NB_QUEUES-1:0][15:0] miss_cnt;
  logic [NB_QUEUES-1:0]       miss_evt_q;

  // Saturating count of miss episodes (rising edges of the miss condition)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_cnt   <= '0;
      miss_evt_q <= '0;
    end else begin
      miss_evt_q <= miss_evt;
      for (int i = 0; i < NB_QUEUES; i++) begin
        if (miss_clear[i])
          miss_cnt[i] <= '0;
        else if (miss_evt[i] && !miss_evt_q[i] && (miss_cnt[i] != 16'hFFFF))
          miss_cnt[i] <= miss_cnt[i] + 16'd1;
      end
    end
  end

  assign miss_count = miss_cnt;
`endif

endmodule

// File: tb/tb_edf_dispatcher.sv
// tb/tb_edf_dispatcher.sv - self-checking bench for edf_dispatcher against a deadline-time reference model
module tb_edf_dispatcher;
  import memoredf_pkg::*;

  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int RW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NQ*DW-1:0]  q_valueOut;
  logic [NQ-1:0]     q_empty;
  logic [NQ-1:0]     q_consumed;
  logic [NQ*RW-1:0]  period;
  logic [NQ-1:0]     miss_clear;
  logic [NQ-1:0]     deadline_miss;
`ifdef MEMOREDF_MISS_CNT_EN
  logic [NQ*16-1:0]  miss_count;
`endif

  edf_dispatcher_if #(.NB_QUEUES(NQ), .DATA_SIZE(DW)) mif ();

  edf_dispatcher #(.NB_QUEUES(NQ), .DATA_SIZE(DW), .REGISTER_SIZE(RW)) dut (
    .clock         (clock),
    .reset         (reset),
    .q_valueOut    (q_valueOut),
    .q_empty       (q_empty),
    .q_consumed    (q_consumed),
    .period        (period),
    .miss_clear    (miss_clear),
    .deadline_miss (deadline_miss),
`ifdef MEMOREDF_MISS_CNT_EN
    .miss_count    (miss_count),
`endif
    .mem           (mif)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Upstream queues and software-controlled inputs
  logic [7:0]  fifo [NQ][$];
  int          per [NQ];
  logic        rdy;
  logic [NQ-1:0] mclr;

  // Reference model: absolute deadline cycle and earliest-eligible cycle per queue
  int          now;
  int          dl  [NQ];
  int          blk [NQ];
  logic        mv;
  logic [7:0]  md;
  logic [1:0]  ms;
  logic [3:0]  mcons;
  logic [3:0]  mmiss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    now = 0;
    for (int i = 0; i < NQ; i++) begin
      dl[i]  = 0;
      blk[i] = 0;
      fifo[i].delete();
    end
    mv = 1'b0; md = '0; ms = '0; mcons = '0; mmiss = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NQ; i++) begin
      q_empty[i]           = (fifo[i].size() == 0);
      q_valueOut[i*DW +: DW] = (fifo[i].size() != 0) ? fifo[i][0] : 8'h00;
      period[i*RW +: RW]   = per[i];
    end
    miss_clear  = mclr;
    mif.m_ready = rdy;
  endtask

  // One clock edge of the model, using the inputs that were presented during the cycle
  task automatic model_edge();
    int   prev;
    int   best;
    int   rem [NQ];
    logic el  [NQ];
    prev = now;
    now  = now + 1;
    for (int i = 0; i < NQ; i++) begin
      rem[i] = (dl[i] > prev) ? dl[i] - prev : 0;
      el[i]  = !q_empty[i] && (prev >= blk[i]);
    end
    best = -1;
    for (int i = 0; i < NQ; i++)
      if (el[i] && per[i] != 0 && (best < 0 || rem[i] < rem[best])) best = i;
    if (best < 0)
      for (int i = 0; i < NQ; i++)
        if (el[i] && per[i] == 0 && best < 0) best = i;
    for (int i = 0; i < NQ; i++) begin
      if (q_empty[i] || mcons[i]) dl[i] = now + per[i];
      else if (rem[i] == 0 && per[i] != 0) mmiss[i] = 1'b1;
      if (mclr[i]) mmiss[i] = 1'b0;
    end
    mcons = '0;
    if (!mv || rdy) begin
      if (best >= 0) begin
        mv          = 1'b1;
        mcons[best] = 1'b1;
        ms          = 2'(best);
        md          = fifo[best].pop_front();
        blk[best]   = now + 2;
      end else begin
        mv = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("m_valid", mif.m_valid, mv);
    chk("q_consumed", q_consumed, mcons);
    chk("deadline_miss", deadline_miss, mmiss);
    chk("m_data", mif.m_data, md);
    chk("m_source", mif.m_source, ms);
  endtask

  task automatic cycle();
    drive();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy   = 1'b0;
    mclr  = '0;
    for (int i = 0; i < NQ; i++) per[i] = 0;
    model_reset();
    drive();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  int exp_order [4] = '{1, 2, 0, 3};
  int waited;
  int pick;
  logic [3:0] onehot;

  initial begin
    rdy  = 1'b0;
    mclr = '0;
    for (int i = 0; i < NQ; i++) per[i] = 0;

    // Reset state
    do_reset();
    check_outputs();
    chk("reset_state", dut.state, IDLE);

    // Single queue: dispatch, then two settle cycles before the next head is taken
    fifo[0].push_back(8'hA5);
    cycle();
    chk("single_valid", mif.m_valid, 1'b1);
    chk("single_data", mif.m_data, 8'hA5);
    chk("single_src", mif.m_source, 2'd0);
    chk("single_cons", q_consumed, 4'b0001);
    fifo[0].push_back(8'h3C);
    rdy = 1'b1;
    cycle();
    chk("settle_cons1", q_consumed, 4'b0000);
    cycle();
    chk("settle_cons2", q_consumed, 4'b0000);
    cycle();
    chk("reselect_cons", q_consumed, 4'b0001);
    chk("reselect_data", mif.m_data, 8'h3C);

    // EDF order with back-to-back dispatch: periods {100,20,50,0}
    do_reset();
    per[0] = 100; per[1] = 20; per[2] = 50; per[3] = 0;
    cycle();
    for (int i = 0; i < NQ; i++) fifo[i].push_back(8'h10 + 8'(i));
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      onehot = 4'b0001 << exp_order[k];
      chk($sformatf("edf_order%0d", k), mif.m_source, exp_order[k]);
      chk($sformatf("b2b_cons%0d", k), q_consumed, onehot);
    end

    // Tie on equal remaining deadlines goes to the lower index
    do_reset();
    per[0] = 30; per[1] = 30;
    cycle();
    fifo[0].push_back(8'h01);
    fifo[1].push_back(8'h02);
    rdy = 1'b1;
    cycle();
    chk("tie_first", mif.m_source, 2'd0);
    cycle();
    chk("tie_second", mif.m_source, 2'd1);

    // Backpressure: output held, no further pops
    do_reset();
    fifo[0].push_back(8'h55);
    fifo[1].push_back(8'h66);
    fifo[2].push_back(8'h77);
    cycle();
    chk("bp_first", mif.m_data, 8'h55);
    repeat (10) begin
      cycle();
      chk("bp_data", mif.m_data, 8'h55);
      chk("bp_src", mif.m_source, 2'd0);
      chk("bp_cons", q_consumed, 4'b0000);
    end
    rdy = 1'b1;
    cycle();
    chk("bp_release_src", mif.m_source, 2'd1);

    // Asynchronous reset while an entry is in flight
    rdy = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_valid", mif.m_valid, 1'b0);
    chk("rst_cons", q_consumed, 4'b0000);
    do_reset();
    chk("rst_idle", dut.state, IDLE);
    check_outputs();

    // Deadline miss: pop, fresh reload on the consumed strobe, then six countdown cycles
    do_reset();
    per[2] = 5;
    cycle();
    fifo[2].push_back(8'hC1);
    fifo[2].push_back(8'hC2);
    waited = 0;
    while (deadline_miss[2] !== 1'b1 && waited < 30) begin
      cycle();
      waited++;
    end
    chk("miss_set", deadline_miss[2], 1'b1);
    chk("miss_latency", waited, 8);
    mclr = 4'b0100;
    cycle();
    chk("miss_clear", deadline_miss[2], 1'b0);
    mclr = '0;
    cycle();
    chk("miss_reassert", deadline_miss[2], 1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < NQ; i++) per[i] = $urandom_range(0, 12);
    repeat (400) begin
      for (int i = 0; i < NQ; i++)
        if ($urandom_range(0, 3) == 0 && fifo[i].size() < 4) fifo[i].push_back(8'($urandom));
      if ($urandom_range(0, 15) == 0) begin
        pick = $urandom_range(0, NQ - 1);
        per[pick] = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 12) : 0;
      end
      rdy  = ($urandom_range(0, 2) != 0);
      mclr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
